// File: rtl/cache_refill_arbiter_if.sv
// rtl/cache_refill_arbiter_if.sv - cache refill request/response and AXI read channel bundle
// master: arbiter side; slave: caches and memory side.
interface cache_refill_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = 8
);
   localparam int LINE_W = BEATS * DATA_W;

   logic              i_req_i;
   logic [ADDR_W-1:0] i_addr_i;
   logic              i_rvalid_o;
   logic [LINE_W-1:0] i_rdata_o;
   logic              d_req_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic              d_rvalid_o;
   logic [LINE_W-1:0] d_rdata_o;
   logic              m_arvalid_o;
   logic              m_arready_i;
   logic [ADDR_W-1:0] m_araddr_o;
   logic [7:0]        m_arlen_o;
   logic [2:0]        m_arsize_o;
   logic [1:0]        m_arburst_o;
   logic              m_rvalid_i;
   logic              m_rready_o;
   logic [DATA_W-1:0] m_rdata_i;
   logic              m_rlast_i;

   modport master (
      input  i_req_i, i_addr_i, d_req_i, d_addr_i,
      input  m_arready_i, m_rvalid_i, m_rdata_i, m_rlast_i,
      output i_rvalid_o, i_rdata_o, d_rvalid_o, d_rdata_o,
      output m_arvalid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o, m_rready_o
   );

   modport slave (
      output i_req_i, i_addr_i, d_req_i, d_addr_i,
      output m_arready_i, m_rvalid_i, m_rdata_i, m_rlast_i,
      input  i_rvalid_o, i_rdata_o, d_rvalid_o, d_rdata_o,
      input  m_arvalid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o, m_rready_o
   );
endinterface

// File: rtl/cache_refill_arbiter.sv
// rtl/cache_refill_arbiter.sv - shares one burst read port between ICache and DCache line refills
// Tie-break: CACHE_ARB_RR_EN selects round-robin; default is fixed DCache priority.
module cache_refill_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int BEATS  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   cache_refill_arbiter_if.master bus
);
   localparam int LINE_W = BEATS * DATA_W;
   localparam int CNT_W  = $clog2(BEATS);
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  beat_cnt;
   logic [LINE_W-1:0] line;
   logic              grant;
   logic [ADDR_W-1:0] addr_q;
   logic              any_req;
   logic              win_d;
   logic              unused_rlast;

   assign any_req      = bus.i_req_i | bus.d_req_i;
   assign unused_rlast = bus.m_rlast_i;

`ifdef CACHE_ARB_RR_EN
   logic last_grant;

   always_comb begin
      win_d = bus.d_req_i;
      if (bus.i_req_i && bus.d_req_i)
         win_d = ~last_grant;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_grant <= 1'b0;
      else if (state == RESP)
         last_grant <= grant;
   end
`else
   always_comb begin
      win_d = bus.d_req_i;
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (any_req) state_nxt = ADDR;
         ADDR: if (bus.m_arready_i) state_nxt = DATA;
         DATA: if (bus.m_rvalid_i && beat_cnt == LAST_BEAT) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Beat count alone ends the burst; m_rlast_i is deliberately not trusted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt <= '0;
         line     <= '0;
         grant    <= 1'b0;
         addr_q   <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               grant  <= win_d;
               addr_q <= (win_d ? bus.d_addr_i : bus.i_addr_i) & ~OFF_MASK;
            end
            ADDR: if (bus.m_arready_i) beat_cnt <= '0;
            DATA: if (bus.m_rvalid_i) begin
               line[beat_cnt*DATA_W +: DATA_W] <= bus.m_rdata_i;
               beat_cnt                        <= beat_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.m_arvalid_o = (state == ADDR);
   assign bus.m_araddr_o  = addr_q;
   assign bus.m_arlen_o   = 8'(BEATS - 1);
   assign bus.m_arsize_o  = 3'b010;
   assign bus.m_arburst_o = 2'b01;
   assign bus.m_rready_o  = (state == DATA);
   assign bus.i_rvalid_o  = (state == RESP) && !grant;
   assign bus.d_rvalid_o  = (state == RESP) && grant;
   assign bus.i_rdata_o   = line;
   assign bus.d_rdata_o   = line;
endmodule

// File: tb/tb_cache_refill_arbiter.sv
// tb/tb_cache_refill_arbiter.sv - directed bench for cache_refill_arbiter
module tb_cache_refill_arbiter;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cyc;
   int   ar_cyc;
   int   rv_cyc;
   int   start;

   cache_refill_arbiter_if #(.ADDR_W(32), .DATA_W(32), .BEATS(8)) bus ();

   cache_refill_arbiter #(.ADDR_W(32), .DATA_W(32), .BEATS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " arvalid"}, 256'(bus.m_arvalid_o), 256'(0));
      check({tag, " rready"},  256'(bus.m_rready_o),  256'(0));
      check({tag, " i_rvalid"}, 256'(bus.i_rvalid_o), 256'(0));
      check({tag, " d_rvalid"}, 256'(bus.d_rvalid_o), 256'(0));
      check({tag, " araddr"},  256'(bus.m_araddr_o),  256'(0));
      check({tag, " rdata"},   bus.d_rdata_o | bus.i_rdata_o, 256'(0));
   endtask

   // Acts as memory for one burst; word k of the line is seed*(k+1).
   task automatic serve(input string tag, input logic [31:0] exp_addr, input bit exp_d,
                        input int ar_wait, input logic [7:0] gap_after, input logic [31:0] seed,
                        input bit rlast_early, output int ar_at, output int rv_at);
      int n;
      logic [255:0] exp_line;
      n = 0;
      while (!bus.m_arvalid_o && n < 40) begin
         step();
         n++;
      end
      ar_at = cyc;
      check({tag, " arvalid"}, 256'(bus.m_arvalid_o), 256'(1));
      check({tag, " araddr"},  256'(bus.m_araddr_o),  256'(exp_addr));
      check({tag, " arlen"},   256'(bus.m_arlen_o),   256'(7));
      check({tag, " arsize"},  256'(bus.m_arsize_o),  256'(2));
      check({tag, " arburst"}, 256'(bus.m_arburst_o), 256'(1));
      for (int w = 0; w < ar_wait; w++) begin
         step();
         check({tag, " arvalid held"}, 256'(bus.m_arvalid_o), 256'(1));
         check({tag, " araddr stable"}, 256'(bus.m_araddr_o), 256'(exp_addr));
      end
      bus.m_arready_i = 1'b1;
      step();
      bus.m_arready_i = 1'b0;
      check({tag, " rready"}, 256'(bus.m_rready_o), 256'(1));
      exp_line = '0;
      for (int k = 0; k < 8; k++) begin
         exp_line[k*32 +: 32] = seed * (k + 1);
         bus.m_rvalid_i = 1'b1;
         bus.m_rdata_i  = seed * (k + 1);
         bus.m_rlast_i  = rlast_early ? (k == 3) : (k == 7);
         step();
         bus.m_rvalid_i = 1'b0;
         bus.m_rlast_i  = 1'b0;
         bus.m_rdata_i  = 32'hDEAD_BEEF;
         if (gap_after[k] && k < 7) begin
            check({tag, " rvalid during gap"}, 256'(bus.i_rvalid_o | bus.d_rvalid_o), 256'(0));
            step();
         end
      end
      rv_at = cyc;
      check({tag, " i_rvalid"}, 256'(bus.i_rvalid_o), 256'(!exp_d));
      check({tag, " d_rvalid"}, 256'(bus.d_rvalid_o), 256'(exp_d));
      check({tag, " line"}, exp_d ? bus.d_rdata_o : bus.i_rdata_o, exp_line);
      if (exp_d) bus.d_req_i = 1'b0;
      else       bus.i_req_i = 1'b0;
      step();
      check({tag, " single pulse"}, 256'(bus.i_rvalid_o | bus.d_rvalid_o), 256'(0));
      check({tag, " line held"}, bus.i_rdata_o, exp_line);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      cyc = 0;
      rst = 1'b0;
      bus.i_req_i = 1'b0;
      bus.i_addr_i = '0;
      bus.d_req_i = 1'b0;
      bus.d_addr_i = '0;
      bus.m_arready_i = 1'b0;
      bus.m_rvalid_i = 1'b0;
      bus.m_rdata_i = '0;
      bus.m_rlast_i = 1'b0;

      // 1: reset held with inputs toggling
      for (int i = 0; i < 6; i++) begin
         bus.i_req_i = 1'($urandom);
         bus.d_req_i = 1'($urandom);
         bus.i_addr_i = $urandom;
         bus.d_addr_i = $urandom;
         bus.m_arready_i = 1'($urandom);
         bus.m_rvalid_i = 1'($urandom);
         bus.m_rdata_i = $urandom;
         bus.m_rlast_i = 1'($urandom);
         step();
         check_idle_outputs("reset");
         check("reset arlen", 256'(bus.m_arlen_o), 256'(7));
      end
      bus.i_req_i = 1'b0;
      bus.d_req_i = 1'b0;
      bus.m_arready_i = 1'b0;
      bus.m_rvalid_i = 1'b0;
      bus.m_rlast_i = 1'b0;
      step();
      rst = 1'b1;
      step();
      step();
      check_idle_outputs("post reset idle");

      // 2: ICache refill, no wait states, latency check
      bus.i_req_i = 1'b1;
      bus.i_addr_i = 32'h1FC0_0014;
      start = cyc;
      serve("icache basic", 32'h1FC0_0000, 1'b0, 0, 8'h00, 32'h11, 1'b0, ar_cyc, rv_cyc);
      check("arvalid latency", 256'(ar_cyc - start), 256'(1));
      check("rvalid latency", 256'(rv_cyc - start), 256'(10));
      check("word0", 256'(bus.i_rdata_o[31:0]), 256'(32'h11));
      check("word7", 256'(bus.i_rdata_o[255:224]), 256'(32'h88));

      // 3: backpressure on AR and gaps in R
      bus.d_req_i = 1'b1;
      bus.d_addr_i = 32'h8000_00FF;
      serve("backpressure", 32'h8000_00E0, 1'b1, 3, 8'b0001_0010, 32'h0101_0101, 1'b0, ar_cyc, rv_cyc);

      // 4: simultaneous requests
      bus.i_req_i = 1'b1;
      bus.i_addr_i = 32'h100;
      bus.d_req_i = 1'b1;
      bus.d_addr_i = 32'h200;
      serve("tie first", 32'h200, 1'b1, 0, 8'h00, 32'hA0, 1'b0, ar_cyc, rv_cyc);
      serve("tie second", 32'h100, 1'b0, 0, 8'h00, 32'hB0, 1'b0, ar_cyc, rv_cyc);
      bus.i_req_i = 1'b1;
      bus.d_req_i = 1'b1;
`ifdef CACHE_ARB_RR_EN
      // last_grant is I after the second burst, so the tie goes to D
      serve("retie first", 32'h200, 1'b1, 1, 8'h00, 32'hC0, 1'b0, ar_cyc, rv_cyc);
      serve("retie second", 32'h100, 1'b0, 0, 8'h00, 32'hD0, 1'b0, ar_cyc, rv_cyc);
`else
      serve("retie first", 32'h200, 1'b1, 1, 8'h00, 32'hC0, 1'b0, ar_cyc, rv_cyc);
      serve("retie second", 32'h100, 1'b0, 0, 8'h00, 32'hD0, 1'b0, ar_cyc, rv_cyc);
`endif

      // 5: early rlast is ignored
      bus.i_req_i = 1'b1;
      bus.i_addr_i = 32'h0000_0040;
      serve("early rlast", 32'h0000_0040, 1'b0, 0, 8'h00, 32'h1234_0001, 1'b1, ar_cyc, rv_cyc);

      // 6: reset mid-burst, then a clean refill
      bus.d_req_i = 1'b1;
      bus.d_addr_i = 32'h0000_003C;
      for (int n = 0; n < 40 && !bus.m_arvalid_o; n++) step();
      check("midrst arvalid", 256'(bus.m_arvalid_o), 256'(1));
      bus.m_arready_i = 1'b1;
      step();
      bus.m_arready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.m_rvalid_i = 1'b1;
         bus.m_rdata_i = 32'h5500 + k;
         step();
      end
      check("midrst rready before", 256'(bus.m_rready_o), 256'(1));
      #2;
      rst = 1'b0;
      #1;
      check_idle_outputs("midrst");
      bus.m_rvalid_i = 1'b0;
      bus.d_req_i = 1'b0;
      step();
      rst = 1'b1;
      step();
      check_idle_outputs("after midrst");
      bus.i_req_i = 1'b1;
      bus.i_addr_i = 32'h2000_0047;
      start = cyc;
      serve("clean refill", 32'h2000_0040, 1'b0, 0, 8'h00, 32'h0F0F_0003, 1'b0, ar_cyc, rv_cyc);
      check("clean rvalid latency", 256'(rv_cyc - start), 256'(10));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
